// File: rtl/pipe_seq_ctrl.sv
// Per-stage enable sequencer for the 16-bit core with a memory-ready timeout, halt and retire counter.
// Build option SKIP_MEM_EN: non-memory instructions go from ALU straight to WB, bypassing MEM.
//
// state   | meaning
// IDLE    | waiting for I_run
// FETCH   | instruction fetch, waits on I_mem_ready
// DECODE  | instruction decode
// REGREAD | register-file read
// ALU     | execute
// MEM     | data access, waits on I_mem_ready
// WB      | writeback, retires the instruction
// HALT    | terminal, left only through reset
module pipe_seq_ctrl #(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             I_clk,
   input  logic             I_rst_n,
   input  logic             I_run,
   input  logic             I_mem_ready,
   input  logic             I_memop,
   input  logic             I_halt,
   output logic             o_en_fetch,
   output logic             o_en_dec,
   output logic             o_en_rf,
   output logic             o_en_alu,
   output logic             o_en_mem,
   output logic             o_en_wb,
   output logic             o_pc_inc,
   output logic [2:0]       o_state,
   output logic             o_halted,
   output logic             o_fault,
   output logic [CNT_W-1:0] o_icount
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_DECODE  = 3'd2;
   localparam logic [2:0] S_REGREAD = 3'd3;
   localparam logic [2:0] S_ALU     = 3'd4;
   localparam logic [2:0] S_MEM     = 3'd5;
   localparam logic [2:0] S_WB      = 3'd6;
   localparam logic [2:0] S_HALT    = 3'd7;

   localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

   logic [2:0]       state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] icount_q, icount_d;

`ifndef SKIP_MEM_EN
   logic memop_unused;
   assign memop_unused = I_memop;
`endif

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      fault_d  = fault_q;
      icount_d = icount_q;
      case (state_q)
         S_IDLE: begin
            if (I_run) begin
               state_d = S_FETCH;
               wait_d  = 8'd0;
            end
         end
         S_FETCH, S_MEM: begin
            // wait_q equals the number of cycles already spent waiting in this state
            if (I_mem_ready) begin
               state_d = (state_q == S_FETCH) ? S_DECODE : S_WB;
            end else if (wait_q == WAIT_LIM) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE:  state_d = S_REGREAD;
         S_REGREAD: state_d = S_ALU;
         S_ALU: begin
`ifdef SKIP_MEM_EN
            if (I_memop) begin
               state_d = S_MEM;
               wait_d  = 8'd0;
            end else begin
               state_d = S_WB;
            end
`else
            state_d = S_MEM;
            wait_d  = 8'd0;
`endif
         end
         S_WB: begin
            icount_d = icount_q + 1'b1;
            if (I_halt) begin
               state_d = S_HALT;
            end else if (I_run) begin
               state_d = S_FETCH;
               wait_d  = 8'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q  <= S_IDLE;
         wait_q   <= 8'd0;
         fault_q  <= 1'b0;
         icount_q <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         fault_q  <= fault_d;
         icount_q <= icount_d;
      end
   end

   assign o_en_fetch = (state_q == S_FETCH);
   assign o_en_dec   = (state_q == S_DECODE);
   assign o_en_rf    = (state_q == S_REGREAD);
   assign o_en_alu   = (state_q == S_ALU);
   assign o_en_mem   = (state_q == S_MEM);
   assign o_en_wb    = (state_q == S_WB);
   assign o_pc_inc   = (state_q == S_FETCH) && I_mem_ready;
   assign o_state    = state_q;
   assign o_halted   = (state_q == S_HALT);
   assign o_fault    = fault_q;
   assign o_icount   = icount_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl: instruction-level timing model, reactive memory driver, per-retire monitor.
module tb_pipe_seq_ctrl;

   localparam int WAIT_MAX = 5;
   localparam int CNT_W    = 4;
   localparam int IC_MOD   = 1 << CNT_W;

   logic             I_clk = 1'b0;
   logic             I_rst_n = 1'b0;
   logic             I_run = 1'b0;
   logic             I_mem_ready = 1'b0;
   logic             I_memop = 1'b0;
   logic             I_halt = 1'b0;
   logic             o_en_fetch, o_en_dec, o_en_rf, o_en_alu, o_en_mem, o_en_wb;
   logic             o_pc_inc, o_halted, o_fault;
   logic [2:0]       o_state;
   logic [CNT_W-1:0] o_icount;

   pipe_seq_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
      .I_clk(I_clk), .I_rst_n(I_rst_n), .I_run(I_run), .I_mem_ready(I_mem_ready),
      .I_memop(I_memop), .I_halt(I_halt),
      .o_en_fetch(o_en_fetch), .o_en_dec(o_en_dec), .o_en_rf(o_en_rf), .o_en_alu(o_en_alu),
      .o_en_mem(o_en_mem), .o_en_wb(o_en_wb), .o_pc_inc(o_pc_inc), .o_state(o_state),
      .o_halted(o_halted), .o_fault(o_fault), .o_icount(o_icount)
   );

   always #5 I_clk = ~I_clk;

   // fw/mw: cycles the memory keeps ready low in FETCH / MEM
   typedef struct {int fw; int mw; bit halt; bit memop;} rec_t;
   typedef struct {int fetch_cyc; int mem_cyc; int pc; bit fault; int icount;} exp_t;

   rec_t drv_q[$];
   exp_t exp_q[$];
   rec_t cur = '{default: 0};
   int   n_checks = 0;
   int   n_errors = 0;
   int   model_ic = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge I_clk);
      #1;
   endtask

   function automatic exp_t model(input rec_t r, input int ic);
      exp_t e;
      bit   has_mem;
`ifdef SKIP_MEM_EN
      has_mem = r.memop;
`else
      has_mem = 1'b1;
`endif
      if (r.fw > WAIT_MAX)
         e = '{fetch_cyc: WAIT_MAX + 1, mem_cyc: 0, pc: 0, fault: 1'b1, icount: ic};
      else if (has_mem && r.mw > WAIT_MAX)
         e = '{fetch_cyc: r.fw + 1, mem_cyc: WAIT_MAX + 1, pc: 1, fault: 1'b1, icount: ic};
      else
         e = '{fetch_cyc: r.fw + 1, mem_cyc: has_mem ? r.mw + 1 : 0, pc: 1, fault: 1'b0, icount: ic};
      return e;
   endfunction

   task automatic push_instr(input rec_t r);
      exp_t e;
      e = model(r, model_ic);
      drv_q.push_back(r);
      exp_q.push_back(e);
      if (!e.fault) model_ic = (model_ic + 1) % IC_MOD;
   endtask

   function automatic int rnd_wait();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) return int'($urandom_range(0, 2));
      if (r < 8) return WAIT_MAX;
      return WAIT_MAX - 1;
   endfunction

   // cond 0: IDLE, 1: halted, 2: last queued instruction in REGREAD
   task automatic wait_cond(input int cond, input string name);
      int n;
      bit ok;
      n = 0;
      forever begin
         case (cond)
            0:       ok = (o_state == 3'd0);
            1:       ok = o_halted;
            default: ok = o_en_rf && (drv_q.size() == 0);
         endcase
         if (ok) break;
         if (n >= 3000) begin
            chk({name, "_timeout"}, n, 0);
            break;
         end
         step();
         n++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"}, int'(o_state), 0);
      chk({tag, "_icount"}, int'(o_icount), 0);
      chk({tag, "_fault"}, int'(o_fault), 0);
      chk({tag, "_halted"}, int'(o_halted), 0);
      chk({tag, "_enables"}, int'({o_en_fetch, o_en_dec, o_en_rf, o_en_alu, o_en_mem, o_en_wb, o_pc_inc}), 0);
   endtask

   task automatic async_reset();
      @(posedge I_clk);
      #3 I_rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      I_run = 1'b0;
      drv_q.delete();
      exp_q.delete();
      model_ic = 0;
      repeat (2) @(posedge I_clk);
      @(negedge I_clk);
      I_rst_n = 1'b1;
   endtask

   task automatic start_run();
      I_run = 1'b1;
      step();
      chk("start_fetch", int'(o_state), 1);
   endtask

   // memory/decoder model: reacts to the stage enables just after each edge
   int fk = 0;
   int mk = 0;
   initial begin
      forever begin
         step();
         I_mem_ready = 1'b0;
         if (!I_rst_n) begin
            fk = 0;
            mk = 0;
            continue;
         end
         if (o_en_fetch) begin
            if (fk == 0) begin
               if (drv_q.size() > 0) cur = drv_q.pop_front();
               else cur = '{default: 0};
            end
            I_mem_ready = (fk >= cur.fw);
            fk++;
         end else begin
            fk = 0;
         end
         if (o_en_mem) begin
            I_mem_ready = (mk >= cur.mw);
            mk++;
         end else begin
            mk = 0;
         end
         I_memop = cur.memop;
         I_halt  = cur.halt;
      end
   end

   // monitor: accumulates per-instruction activity, scores at retire or halt
   int nf = 0, nm = 0, nmid = 0, npc = 0, last_ic = 0;
   bit halted_seen = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge I_clk);
         if (!I_rst_n) begin
            nf = 0; nm = 0; nmid = 0; npc = 0;
            halted_seen = 1'b0;
            continue;
         end
         nf   += int'(o_en_fetch);
         nm   += int'(o_en_mem);
         nmid += int'(o_en_dec) + int'(o_en_rf) + int'(o_en_alu);
         npc  += int'(o_pc_inc);
         if (o_en_wb) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_retire", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("fetch_cycles", nf, e.fetch_cyc);
               chk("mem_cycles", nm, e.mem_cyc);
               chk("mid_cycles", nmid, 3);
               chk("pc_inc_pulses", npc, e.pc);
               chk("icount_at_wb", int'(o_icount), e.icount);
               chk("fault_at_wb", int'(o_fault), 0);
               last_ic = e.icount;
            end
            nf = 0; nm = 0; nmid = 0; npc = 0;
         end else if (o_halted && !halted_seen) begin
            halted_seen = 1'b1;
            if (exp_q.size() > 0 && exp_q[0].fault) begin
               e = exp_q.pop_front();
               chk("fault_fetch_cycles", nf, e.fetch_cyc);
               chk("fault_mem_cycles", nm, e.mem_cyc);
               chk("fault_pc_inc", npc, e.pc);
               chk("fault_flag", int'(o_fault), 1);
               chk("fault_icount", int'(o_icount), e.icount);
            end else begin
               chk("halt_no_fault", int'(o_fault), 0);
               chk("halt_icount", int'(o_icount), (last_ic + 1) % IC_MOD);
            end
            nf = 0; nm = 0; nmid = 0; npc = 0;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not end, got time %0t expected finish", $time);
      $fatal(1);
   end

   initial begin
      rec_t r;
      int   n, kind;

      #2 check_reset_outputs("reset");
      repeat (3) @(posedge I_clk);
      @(negedge I_clk);
      I_rst_n = 1'b1;
      step();
      chk("idle_without_run", int'(o_state), 0);

      // zero-wait back-to-back: state walks 1..6, three retirements in 18 cycles
      for (int i = 0; i < 4; i++) push_instr('{fw: 0, mw: 0, halt: 1'b0, memop: 1'b1});
      start_run();
      for (int i = 0; i < 18; i++) begin
         chk("seq_state", int'(o_state), (i % 6) + 1);
         step();
      end
      chk("icount_after_18", int'(o_icount), 3);
      I_run = 1'b0;
      wait_cond(0, "seq_idle");
      chk("seq_queue_drained", exp_q.size(), 0);

      // random episodes; each ends by run drop, HALT instruction or memory timeout
      for (int ep = 0; ep < 14; ep++) begin
         n    = (ep == 0) ? 20 : int'($urandom_range(1, 22));
         kind = (ep < 4) ? ep : int'($urandom_range(0, 3));
         for (int i = 0; i < n - 1; i++) begin
            r = '{fw: rnd_wait(), mw: rnd_wait(), halt: 1'b0, memop: 1'($urandom_range(0, 1))};
            push_instr(r);
         end
         r = '{fw: rnd_wait(), mw: rnd_wait(), halt: 1'b0, memop: 1'($urandom_range(0, 1))};
         if (kind == 1) r.halt = 1'b1;
         if (kind == 2) r.fw = WAIT_MAX + int'($urandom_range(1, 3));
         if (kind == 3) begin
            r.mw    = WAIT_MAX + int'($urandom_range(1, 3));
            r.memop = 1'b1;
         end
         push_instr(r);
         start_run();
         if (kind == 0) begin
            wait_cond(2, "drop_regread");
            I_run = 1'b0;
            wait_cond(0, "drop_idle");
            for (int i = 0; i < 3; i++) begin
               step();
               chk("idle_holds", int'(o_state), 0);
            end
            chk("drop_queue_drained", exp_q.size(), 0);
         end else begin
            wait_cond(1, "halt_entry");
            for (int i = 0; i < 4; i++) begin
               I_run = ~I_run;
               step();
               chk("halt_sticky", int'(o_state), 7);
               chk("halt_fault_level", int'(o_fault), (kind == 1) ? 0 : 1);
            end
            chk("halt_queue_drained", exp_q.size(), 0);
            async_reset();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit core; drives the per-stage enables of fetch, instruction decoder, register file, ALU, memory access and writeback.
- Stages run one at a time: each instruction walks FETCH -> DECODE -> REGREAD -> ALU -> MEM -> WB.
- Adds a memory-ready handshake with timeout, a halt path and a retired-instruction counter.
- Sits between the top-level run control and the datapath stage enable inputs (`I_en` of each stage).

Parameters:
- `WAIT_MAX`, 15, maximum cycles spent waiting for `I_mem_ready` in FETCH or MEM before fault; legal 1..255.
- `CNT_W`, 16, width of the retired-instruction counter `o_icount`.

Ports:
- `I_clk`  input  1  core clock; all state changes on posedge.
- `I_rst_n`  input  1  asynchronous active-low reset.
- `I_run`  input  1  start/continue execution; level-sensitive.
- `I_mem_ready`  input  1  memory completes the current fetch/access this cycle.
- `I_memop`  input  1  decoded instruction is a load/store; valid from ALU state onward.
- `I_halt`  input  1  decoded instruction is HALT; sampled in WB.
- `o_en_fetch`  output  1  fetch stage enable / memory request (instruction).
- `o_en_dec`  output  1  instruction decoder enable.
- `o_en_rf`  output  1  register-file read enable.
- `o_en_alu`  output  1  ALU enable.
- `o_en_mem`  output  1  data memory request.
- `o_en_wb`  output  1  writeback enable; gated externally with decoder `o_regwe`.
- `o_pc_inc`  output  1  single-cycle PC increment pulse.
- `o_state`  output  3  encoded current state, for debug.
- `o_halted`  output  1  core in HALT state.
- `o_fault`  output  1  sticky memory-timeout fault.
- `o_icount`  output  CNT_W  retired-instruction count.

Behaviour:
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, REGREAD=3, ALU=4, MEM=5, WB=6, HALT=7.
  - State register is reset asynchronously by `I_rst_n`=0.
- Reset values:
  - state=IDLE, `o_icount`=0, `o_fault`=0, wait counter=0.
  - All enables and `o_pc_inc` = 0, `o_halted`=0.
- Output decoding: Moore; each enable is high for exactly the cycles spent in its state.
  - `o_en_fetch` in FETCH, `o_en_dec` in DECODE, `o_en_rf` in REGREAD, `o_en_alu` in ALU, `o_en_mem` in MEM, `o_en_wb` in WB.
  - `o_halted` = (state==HALT).
- State transitions:
  - IDLE: to FETCH when `I_run`=1, else hold.
  - FETCH: to DECODE when `I_mem_ready`=1, else hold and increment the wait counter.
  - DECODE -> REGREAD -> ALU: unconditional, one cycle each.
  - ALU: to MEM (see Optional Feature for the skip case).
  - MEM: to WB when `I_mem_ready`=1, else hold and count.
  - WB: `I_halt`=1 -> HALT; else `I_run`=1 -> FETCH; else IDLE.
  - HALT: terminal; exits only via reset. `I_run` is ignored.
- Wait counter (8 bit):
  - Clears on every entry to FETCH or MEM.
  - While waiting, if the count reaches `WAIT_MAX` with `I_mem_ready`=0: go to HALT and set `o_fault`=1 (sticky until reset).
  - `I_mem_ready`=1 on the same cycle the count reaches `WAIT_MAX` counts as success, not a fault.
- `o_pc_inc`: 1-cycle pulse during the FETCH cycle in which `I_mem_ready`=1.
- `o_icount`: increments by 1 on every exit from WB, including the halting instruction; wraps from 2^CNT_W-1 to 0.
- `I_run` falling mid-instruction: the current instruction completes through WB, then the FSM goes to IDLE.
- `I_rst_n` asserted mid-operation: immediate return to IDLE; all outputs drop asynchronously.
- Minimum latency: 6 cycles per instruction with zero memory wait, 5 with the skip feature on a non-memory op.

Optional Feature:
- Macro: `SKIP_MEM_EN`.
- Defined: in ALU, `I_memop`=0 goes directly to WB and MEM is bypassed; `I_memop`=1 goes to MEM.
- Undefined: ALU always goes to MEM. For a non-memory op the MEM stage still waits on `I_mem_ready`, and the external memory returns ready immediately.

Test Plan:
- Reset then `I_run`=1, `I_mem_ready` tied 1: `o_state` sequence 1,2,3,4,5,6,1…; `o_pc_inc` pulses every 6 cycles; `o_icount`=3 after 18 cycles from first FETCH.
- `I_mem_ready` low for 4 cycles in FETCH (`WAIT_MAX`=15): FETCH held 5 cycles, single `o_pc_inc` pulse, no fault.
- `I_mem_ready` held 0 in MEM with `WAIT_MAX`=3: HALT entered after 3 wait cycles, `o_fault`=1, `o_halted`=1, `I_run` toggling has no effect.
- `I_halt`=1 in WB: next state HALT, `o_icount` incremented; async `I_rst_n`=0 mid-HALT -> IDLE, `o_fault`=0, `o_icount`=0.
- `I_run` dropped during REGREAD: instruction reaches WB, then IDLE; `o_icount`+1; reasserting `I_run` restarts at FETCH.
- With `SKIP_MEM_EN`, `I_memop`=0: ALU->WB, 5-cycle loop, `o_en_mem` never high; `I_memop`=1 visits MEM. With `CNT_W`=4, 16 retirements wrap `o_icount` to 0.
